mem_access_sequencer: RTL

Multi-cycle sequencer between the core's load/store decode and the data-memory port. It accepts one RV32I load or store per request and generates word-aligned memory requests with byte enables. It holds the request until memory acknowledges, then returns sign- or zero-extended read data with a one-cycle `done` pulse. The core stalls on `busy`; `wr`/`werf` decode stays upstream, and this block only sequences the memory transaction.

---
 rtl/mem_access_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: runs one RV32I load or store against a word-wide data
// memory. It produces lane-aligned byte enables and write data, holds the
// request until mem_ack, and returns extended read data with a one-cycle done.
// Optional build macro MISALIGNED_SPLIT_EN: accesses that cross a word
// boundary become two back-to-back requests instead of being rejected.
module mem_access_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ1, REQ2, DONE} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        split_q;
    logic [3:0]  hi_be_q;
    logic [31:0] hi_wdata_q;
    logic [31:0] rd_lo_q;

    logic [1:0]  in_off;
    logic [3:0]  in_mask;
    logic [7:0]  in_be8;
    logic [63:0] in_wd64;
    logic        in_illegal_f3;
    logic        in_misalign;
    logic        in_split;

    // Shift a byte/half/word out of a (possibly two-word) read and extend it.
    function automatic logic [31:0] extract(input logic [63:0] w,
                                            input logic [1:0]  off,
                                            input logic [2:0]  f3);
        logic [31:0] s;
        s = 32'(w >> {off, 3'b000});
        case (f3[1:0])
            2'b00:   return {{24{s[7]  & ~f3[2]}}, s[7:0]};
            2'b01:   return {{16{s[15] & ~f3[2]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign in_off  = addr[1:0];
    // 8-lane views: low nibble/word is the first request, high part spills over.
    assign in_be8  = {4'b0000, in_mask} << in_off;
    assign in_wd64 = {32'b0, wdata} << {in_off, 3'b000};
    assign busy    = (state != IDLE);

    // Decode size mask and legality of the incoming request.
    always_comb begin
        case (funct3[1:0])
            2'b00:   in_mask = 4'b0001;
            2'b01:   in_mask = 4'b0011;
            default: in_mask = 4'b1111;
        endcase
        if (is_store)
            in_illegal_f3 = (funct3 > 3'b010);
        else
            in_illegal_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
`ifdef MISALIGNED_SPLIT_EN
        in_misalign = 1'b0;
        in_split    = |in_be8[7:4];
`else
        in_misalign = ((funct3[1:0] == 2'b01) && in_off[0]) ||
                      ((funct3[1:0] == 2'b10) && (in_off != 2'b00));
        in_split    = 1'b0;
`endif
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            off_q      <= '0;
            f3_q       <= '0;
            split_q    <= 1'b0;
            hi_be_q    <= '0;
            hi_wdata_q <= '0;
            rd_lo_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        off_q      <= in_off;
                        f3_q       <= funct3;
                        split_q    <= in_split;
                        hi_be_q    <= in_be8[7:4];
                        hi_wdata_q <= in_wd64[63:32];
                        if (in_illegal_f3 || in_misalign) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= REQ1;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= in_be8[3:0];
                            mem_wdata <= in_wd64[31:0];
                        end
                    end
                end
                REQ1: begin
                    if (mem_ack) begin
                        if (split_q) begin
                            // mem_req stays high straight into the second word.
                            state     <= REQ2;
                            rd_lo_q   <= mem_rdata;
                            mem_addr  <= mem_addr + 32'd4;
                            mem_be    <= hi_be_q;
                            mem_wdata <= hi_wdata_q;
                        end else begin
                            state     <= DONE;
                            done      <= 1'b1;
                            if (!mem_we)
                                rdata <= extract({32'b0, mem_rdata}, off_q, f3_q);
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_be    <= '0;
                            mem_wdata <= '0;
                        end
                    end
                end
                REQ2: begin
                    if (mem_ack) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        if (!mem_we)
                            rdata <= extract({mem_rdata, rd_lo_q}, off_q, f3_q);
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
